// File: rtl/dm_port_arbiter_if.sv
// Data-memory port bundle: CPU MEM-stage requester, DMA/debug loader requester
// and the single DM port, with master (requester/memory side) and slave
// (arbiter side) views.
interface dm_port_arbiter_if #(
  parameter int unsigned bit_size = 32,
  parameter int unsigned mem_size = 16
);

  // CPU MEM stage
  logic                cpu_req;
  logic                cpu_we;
  logic [mem_size-1:0] cpu_addr;
  logic [bit_size-1:0] cpu_wdata;
  logic [bit_size-1:0] cpu_rdata;
  logic                cpu_stall;

  // DMA / debug loader
  logic                dma_req;
  logic                dma_we;
  logic [mem_size-1:0] dma_addr;
  logic [bit_size-1:0] dma_wdata;
  logic                dma_gnt;
  logic [bit_size-1:0] dma_rdata;
  logic                dma_rvalid;

  // Last grant, 00 idle / 01 CPU / 10 DMA
  logic [1:0]          owner;

  // Data memory port
  logic [mem_size-1:0] DM_Address;
  logic                DM_enable;
  logic [bit_size-1:0] DM_Write_Data;
  logic [bit_size-1:0] DM_Read_Data;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_gnt, dma_rdata, dma_rvalid,
    output owner,
    output DM_Address, DM_enable, DM_Write_Data,
    input  DM_Read_Data
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_gnt, dma_rdata, dma_rvalid,
    input  owner,
    input  DM_Address, DM_enable, DM_Write_Data,
    output DM_Read_Data
  );

endinterface

// File: rtl/dm_port_arbiter.sv
// Data-memory port arbiter. The CPU has fixed priority; a DMA request that has
// been denied MAX_WAIT consecutive cycles is forced through, stalling the CPU
// for that one slot. CPU read data is combinational, DMA read data registered.
// MAX_WAIT must lie in 1..7 and fit in WAIT_W bits.
module dm_port_arbiter #(
  parameter int unsigned bit_size = 32,
  parameter int unsigned mem_size = 16,
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned WAIT_W   = 3
) (
  input logic              clk,
  input logic              rst,
  dm_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StCpu  = 2'b01,
    StDma  = 2'b10
  } owner_e;

  localparam logic [WAIT_W-1:0] WaitMax = WAIT_W'(MAX_WAIT);

  owner_e              owner_q;
  logic [WAIT_W-1:0]   wait_cnt_q;
  logic [bit_size-1:0] dma_rdata_q;
  logic                dma_rvalid_q;

  logic                force_dma;
  logic                dma_win;
  logic                cpu_win;
  logic [mem_size-1:0] dm_addr;
  logic                dm_we;
  logic [bit_size-1:0] dm_wdata;

  // Grant decision; both grants are suppressed while reset is asserted.
  always_comb begin
    force_dma = bus.dma_req && (wait_cnt_q == WaitMax);
    dma_win   = rst && bus.dma_req && (!bus.cpu_req || force_dma);
    cpu_win   = rst && !dma_win && bus.cpu_req;
  end

  // Steer the winner onto the DM port; the port idles at all-zero otherwise.
  always_comb begin
    dm_addr  = '0;
    dm_we    = 1'b0;
    dm_wdata = '0;
    if (dma_win) begin
      dm_addr  = bus.dma_addr;
      dm_we    = bus.dma_we;
      dm_wdata = bus.dma_wdata;
    end else if (cpu_win) begin
      dm_addr  = bus.cpu_addr;
      dm_we    = bus.cpu_we;
      dm_wdata = bus.cpu_wdata;
    end
  end

  assign bus.DM_Address    = dm_addr;
  assign bus.DM_enable     = dm_we;
  assign bus.DM_Write_Data = dm_wdata;
  assign bus.dma_gnt       = dma_win;
  // The CPU only ever loses the port to a DMA grant.
  assign bus.cpu_stall     = dma_win && bus.cpu_req;
  assign bus.cpu_rdata     = bus.DM_Read_Data;
  assign bus.dma_rdata     = dma_rdata_q;
  assign bus.dma_rvalid    = dma_rvalid_q;
  assign bus.owner         = owner_q;

  // Owner FSM tracks last cycle's grant; wait counter measures DMA starvation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q    <= StIdle;
      wait_cnt_q <= '0;
    end else begin
      unique case (owner_q)
        StIdle, StCpu, StDma: begin
          if (dma_win) begin
            owner_q <= StDma;
          end else if (cpu_win) begin
            owner_q <= StCpu;
          end else begin
            owner_q <= StIdle;
          end
        end
        default: owner_q <= StIdle;
      endcase

      // A withdrawn or served request restarts the starvation count.
      if (!bus.dma_req || dma_win) begin
        wait_cnt_q <= '0;
      end else if (wait_cnt_q != WaitMax) begin
        wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
      end
    end
  end

  // Capture DMA read data one cycle after its grant; rvalid is a single pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dma_rdata_q  <= '0;
      dma_rvalid_q <= 1'b0;
    end else begin
      dma_rvalid_q <= dma_win && !bus.dma_we;
      if (dma_win && !bus.dma_we) begin
        dma_rdata_q <= bus.DM_Read_Data;
      end
    end
  end

  // The starvation counter saturates at MAX_WAIT.
  wait_in_range_a: assert property (@(posedge clk) disable iff (!rst) wait_cnt_q <= WaitMax);

  // At most one requester owns the port in any cycle.
  one_grant_a: assert property (@(posedge clk) disable iff (!rst) !(dma_win && cpu_win));

endmodule

// File: doc/dm_port_arbiter.md
Name: dm_port_arbiter

Overview:
- Shares the single data-memory port (DM) between two requesters: the CPU MEM stage and a DMA/debug loader port.
- Sits between the pipeline top and the DM instance.
- The CPU has fixed priority. A starvation counter forces a DMA slot after MAX_WAIT denied cycles, and the CPU is stalled for that slot.
- Each DM access takes one cycle. CPU read data is passed through combinationally; DMA read data is registered.

Parameters:
- bit_size, 32, data width.
- mem_size, 16, DM address width.
- MAX_WAIT, 4, consecutive denied DMA cycles before a forced DMA grant; legal range 1..7.
- WAIT_W, 3, width of the wait counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU MEM stage requests a DM access this cycle.
- cpu_we  in  1  1=write, 0=read.
- cpu_addr  in  mem_size  CPU word address.
- cpu_wdata  in  bit_size  CPU write data.
- cpu_rdata  out  bit_size  CPU read data, combinational from DM_Read_Data.
- cpu_stall  out  1  CPU request not served this cycle; freeze the pipeline.
- dma_req  in  1  DMA requests an access; must hold until dma_gnt.
- dma_we  in  1  1=write, 0=read.
- dma_addr  in  mem_size  DMA word address.
- dma_wdata  in  bit_size  DMA write data.
- dma_gnt  out  1  DMA access performed this cycle.
- dma_rdata  out  bit_size  registered DMA read data.
- dma_rvalid  out  1  dma_rdata valid; one-cycle pulse.
- owner  out  2  registered last grant: 00 IDLE, 01 CPU, 10 DMA.
- DM_Address  out  mem_size  to DM.
- DM_enable  out  1  DM write enable.
- DM_Write_Data  out  bit_size  to DM.
- DM_Read_Data  in  bit_size  from DM; combinational read of DM_Address.

Behaviour:
- Reset (rst=0, asynchronous) sets:
  - owner=IDLE, wait_cnt=0, dma_rvalid=0, dma_rdata=0.
  - While rst=0, the combinational outputs are forced: dma_gnt=0, cpu_stall=0, DM_enable=0, DM_Address=0, DM_Write_Data=0.
- Grant decision (combinational, per cycle):
  - force = dma_req && wait_cnt==MAX_WAIT.
  - If dma_req && (!cpu_req || force): DMA granted.
  - Else if cpu_req: CPU granted.
  - Else: no grant.
- Outputs by grant:
  - CPU granted: DM_Address=cpu_addr, DM_enable=cpu_we, DM_Write_Data=cpu_wdata, cpu_stall=0.
  - DMA granted: DM_Address=dma_addr, DM_enable=dma_we, DM_Write_Data=dma_wdata, dma_gnt=1, cpu_stall=cpu_req.
  - No grant: DM_enable=0, DM_Address=0, DM_Write_Data=0.
- cpu_rdata = DM_Read_Data at all times. It is meaningful only when cpu_req && !cpu_stall.
- wait_cnt (registered):
  - +1 when dma_req && !dma_gnt, saturating at MAX_WAIT.
  - Cleared to 0 when dma_gnt or !dma_req.
- DMA read: when dma_gnt && !dma_we, dma_rdata <= DM_Read_Data and dma_rvalid <= 1 at the next edge. dma_rvalid is 0 in all other cycles.
- DMA write: dma_rvalid stays 0; write completion is signalled by dma_gnt.
- owner FSM (registered grant of the previous cycle):
  - IDLE->CPU on a CPU grant; IDLE->DMA on a DMA grant.
  - CPU->DMA only on a forced or idle-CPU DMA grant.
  - Any state->IDLE on no grant.
  - Self-loops otherwise.
- After a forced grant, wait_cnt=0, so the CPU wins the following MAX_WAIT cycles of contention.
- Simultaneous write by one side and read by the other on the same address cannot occur; only one access per cycle.
- Back-to-back DMA reads: dma_rvalid stays high on consecutive cycles, with new dma_rdata each cycle.
- dma_req deasserted before grant: counter clears, no access happens, and no error is raised.
- Reset mid-operation: pending dma_rvalid is dropped; no DM write happens while rst=0.

Test Plan:
- CPU only: cpu_req=1, cpu_we=1, addr=5, wdata=32'hDEADBEEF, then read addr 5. Required: cpu_stall=0 both cycles, DM_enable=1 then 0, cpu_rdata=32'hDEADBEEF, owner=01.
- DMA only: write addr 9 = 32'h1234 (dma_gnt same cycle), then read addr 9. Required: dma_rvalid=1 one cycle later with dma_rdata=32'h1234, owner=10.
- Contention, MAX_WAIT=4: cpu_req and dma_req held high for 10 cycles. Required:
  - cycles 0-3: CPU granted, wait_cnt 1,2,3,4;
  - cycle 4: dma_gnt=1, cpu_stall=1;
  - cycles 5-8: CPU granted;
  - cycle 9: DMA granted again.
- Idle CPU: cpu_req=0, dma_req=1 for 3 cycles. Required: dma_gnt=1 every cycle, wait_cnt=0 throughout, cpu_stall=0.
- Async reset mid-read: assert rst=0 between a DMA read grant and the next edge. Required: dma_rvalid=0, owner=00, DM_enable=0 immediately, with no clock needed.
- DMA withdraw: dma_req high for 2 denied cycles, then low. Required: wait_cnt returns to 0, no DMA access occurs, CPU traffic is unaffected.
